hamming_decoder_pipe: RTL and testbench

- Receiver-side Hamming(7,4) decoder with single-error correction; pairs with the team's combinational even-parity Hamming(7,4) encoder.
- Accepts 7-bit codewords over a valid/ready stream, computes the syndrome, corrects any single flipped bit and emits the 4-bit data word.
- Two-stage registered pipeline with backpressure. Keeps a saturating count of corrected words for link-health monitoring.

---
 rtl/hamming_pkg.sv | 30 +++
 rtl/hamming_decoder_pipe_syndrome.sv | 11 +
 rtl/hamming_decoder_pipe.sv | 112 +++++++++++
 tb/tb_hamming_decoder_pipe.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) definitions: codeword layout, widths and the even-parity
// syndrome used by both the decoder pipeline and the encoder-side benches.
package hamming_pkg;

    localparam int CODE_W = 7;
    localparam int DATA_W = 4;
    localparam int SYN_W  = 3;

    localparam int P0 = 0;
    localparam int P1 = 1;
    localparam int D0 = 2;
    localparam int P2 = 3;
    localparam int D1 = 4;
    localparam int D2 = 5;
    localparam int D3 = 6;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              err;
        logic [SYN_W-1:0]  pos;
    } dec_word_t;

    // Syndrome value is the 1-based position of a single flipped bit, 0 if clean.
    function automatic logic [SYN_W-1:0] hamming_syndrome_f(input logic [CODE_W-1:0] c);
        return {c[P2] ^ c[D1] ^ c[D2] ^ c[D3],
                c[P1] ^ c[D0] ^ c[D2] ^ c[D3],
                c[P0] ^ c[D0] ^ c[D1] ^ c[D3]};
    endfunction

endpackage

// File: rtl/hamming_decoder_pipe_syndrome.sv
// Combinational Hamming(7,4) syndrome generator feeding the decoder's first stage.
module hamming_syndrome
    import hamming_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic [SYN_W-1:0]  syn
);

    assign syn = hamming_syndrome_f(code);

endmodule

// File: rtl/hamming_decoder_pipe.sv
// Two-stage Hamming(7,4) SEC decoder with valid/ready backpressure and a
// saturating count of words delivered with a nonzero syndrome.
module hamming_decoder_pipe
    import hamming_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int CORRECT_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        code_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        data_out,
    output logic              err_detected,
    output logic [2:0]        err_pos,
    input  logic              clear_count,
    output logic [CNT_W-1:0]  corr_count
);

    logic              vld_p1;
    logic              vld_p2;
    logic              s1_ready;
    logic              s2_ready;
    logic [SYN_W-1:0]  syn_p0;
    logic [CODE_W-1:0] code_p1;
    logic [SYN_W-1:0]  syn_p1;
    dec_word_t         dec_nxt;
    dec_word_t         dec_p2;
    logic [CNT_W-1:0]  cnt;

    // Flip the bit named by the syndrome, then pick out the data positions.
    function automatic logic [DATA_W-1:0] correct_data(input logic [CODE_W-1:0] c,
                                                        input logic [SYN_W-1:0]  s);
        logic [CODE_W-1:0] fixed;
        fixed = c;
        for (int i = 0; i < CODE_W; i++) begin
            if (CORRECT_EN != 0 && s == SYN_W'(i + 1)) begin
                fixed[i] = ~c[i];
            end
        end
        return {fixed[D3], fixed[D2], fixed[D1], fixed[D0]};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign s2_ready = !vld_p2 || out_ready;
    assign s1_ready = !vld_p1 || s2_ready;
    assign in_ready = s1_ready;

    hamming_syndrome u_syn (
        .code (code_in),
        .syn  (syn_p0)
    );

    // Stage 1: codeword and syndrome
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else if (s1_ready) begin
            vld_p1 <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid && s1_ready) begin
            code_p1 <= code_in;
            syn_p1  <= syn_p0;
        end
    end

    always_comb begin
        dec_nxt      = '0;
        dec_nxt.data = correct_data(code_p1, syn_p1);
        dec_nxt.err  = |syn_p1;
        dec_nxt.pos  = syn_p1;
    end

    // Stage 2: corrected data and status, held while the consumer stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p2 <= 1'b0;
            dec_p2 <= '0;
        end else if (s2_ready) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                dec_p2 <= dec_nxt;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear_count) begin
            cnt <= '0;
        end else if (vld_p2 && out_ready && dec_p2.err) begin
            cnt <= sat_inc(cnt);
        end
    end

    assign out_valid    = vld_p2;
    assign data_out     = dec_p2.data;
    assign err_detected = dec_p2.err;
    assign err_pos      = dec_p2.pos;
    assign corr_count   = cnt;

endmodule

// File: tb/tb_hamming_decoder_pipe.sv
// Bench for hamming_decoder_pipe: one instance with correction and an 8-bit
// counter, one with correction off and a 2-bit counter.
module tb_hamming_decoder_pipe;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       a_in_valid = 1'b0, a_out_ready = 1'b0, a_clear = 1'b0;
    logic [6:0] a_code = '0;
    logic       a_in_ready, a_out_valid, a_err;
    logic [3:0] a_data;
    logic [2:0] a_pos;
    logic [7:0] a_cnt;

    logic       b_in_valid = 1'b0, b_out_ready = 1'b0, b_clear = 1'b0;
    logic [6:0] b_code = '0;
    logic       b_in_ready, b_out_valid, b_err;
    logic [3:0] b_data;
    logic [2:0] b_pos;
    logic [1:0] b_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [3:0] data;
        logic       err;
        logic [2:0] pos;
    } exp_t;

    exp_t expq[$];

    hamming_decoder_pipe #(.CNT_W(8), .CORRECT_EN(1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .code_in(a_code), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .data_out(a_data), .err_detected(a_err), .err_pos(a_pos),
        .clear_count(a_clear), .corr_count(a_cnt)
    );

    hamming_decoder_pipe #(.CNT_W(2), .CORRECT_EN(0)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .code_in(b_code), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .data_out(b_data), .err_detected(b_err), .err_pos(b_pos),
        .clear_count(b_clear), .corr_count(b_cnt)
    );

    // Reference: even-parity encoder and a position-XOR syndrome decoder.
    function automatic logic [6:0] encode(input logic [3:0] d);
        logic [6:0] c;
        c    = '0;
        c[2] = d[0]; c[4] = d[1]; c[5] = d[2]; c[6] = d[3];
        c[0] = c[2] ^ c[4] ^ c[6];
        c[1] = c[2] ^ c[5] ^ c[6];
        c[3] = c[4] ^ c[5] ^ c[6];
        return c;
    endfunction

    function automatic exp_t model(input logic [6:0] c, input bit ce);
        int s;
        logic [6:0] f;
        exp_t r;
        s = 0;
        f = c;
        for (int i = 0; i < 7; i++) if (c[i]) s = s ^ (i + 1);
        if (ce && s != 0) f[s-1] = ~f[s-1];
        r.data = {f[6], f[5], f[4], f[2]};
        r.err  = (s != 0);
        r.pos  = s[2:0];
        return r;
    endfunction

    task automatic step_a(input logic v, input logic [6:0] c, input logic ordy, input logic clr,
                          output logic in_x, output logic out_x);
        @(negedge clk);
        a_in_valid = v; a_code = c; a_out_ready = ordy; a_clear = clr;
        #1;
        in_x  = a_in_valid && a_in_ready;
        out_x = a_out_valid && a_out_ready;
    endtask

    task automatic step_b(input logic v, input logic [6:0] c, input logic ordy, input logic clr,
                          output logic in_x, output logic out_x);
        @(negedge clk);
        b_in_valid = v; b_code = c; b_out_ready = ordy; b_clear = clr;
        #1;
        in_x  = b_in_valid && b_in_ready;
        out_x = b_out_valid && b_out_ready;
    endtask

    task automatic test_reset;
        a_in_valid = 1'b0; b_in_valid = 1'b0; a_clear = 1'b0; b_clear = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if ({a_out_valid, a_data, a_err, a_pos, a_cnt} !== '0) begin
            n_bad++;
            $display("FAIL reset_a: valid=%b data=%h err=%b pos=%0d cnt=%0d, want all 0",
                     a_out_valid, a_data, a_err, a_pos, a_cnt);
        end
        n_cmp++;
        if ({b_out_valid, b_data, b_err, b_pos, b_cnt} !== '0) begin
            n_bad++;
            $display("FAIL reset_b: valid=%b data=%h err=%b pos=%0d cnt=%0d, want all 0",
                     b_out_valid, b_data, b_err, b_pos, b_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_in_ready: a=%b b=%b, want 1", a_in_ready, b_in_ready);
        end
    endtask

    task automatic test_clean;
        logic ix, ox;
        logic [6:0] words [3] = '{7'h55, 7'h00, 7'h7F};
        logic [3:0] want  [3] = '{4'hB, 4'h0, 4'hF};
        int in_step [3];
        int k = 0;
        int got = 0;
        for (int t = 0; t < 10; t++) begin
            step_a(k < 3, (k < 3) ? words[k] : 7'h00, 1'b1, 1'b0, ix, ox);
            if (ox) begin
                n_cmp++;
                if (got >= 3) begin
                    n_bad++;
                    $display("FAIL clean_extra: data=%h, want no output", a_data);
                end else if (a_data !== want[got] || a_err !== 1'b0 || a_pos !== 3'd0
                             || t != in_step[got] + 2) begin
                    n_bad++;
                    $display("FAIL clean_word%0d: data=%h err=%b pos=%0d cycle=%0d, want data=%h err=0 pos=0 cycle=%0d",
                             got, a_data, a_err, a_pos, t, want[got], in_step[got] + 2);
                end
                got++;
            end
            if (ix) begin
                in_step[k] = t;
                k++;
            end
        end
        n_cmp++;
        if (got != 3 || a_cnt !== 8'd0) begin
            n_bad++;
            $display("FAIL clean_totals: delivered=%0d cnt=%0d, want 3 and 0", got, a_cnt);
        end
    endtask

    task automatic test_correct;
        logic ix, ox;
        logic [6:0] words [2] = '{7'h45, 7'h7E};
        exp_t       want  [2] = '{{4'hB, 1'b1, 3'd5}, {4'hF, 1'b1, 3'd1}};
        int k = 0;
        int got = 0;
        for (int t = 0; t < 8; t++) begin
            step_a(k < 2, (k < 2) ? words[k] : 7'h00, 1'b1, 1'b0, ix, ox);
            if (ox) begin
                n_cmp++;
                if (got >= 2) begin
                    n_bad++;
                    $display("FAIL correct_extra: data=%h, want no output", a_data);
                end else if ({a_data, a_err, a_pos} !== want[got]) begin
                    n_bad++;
                    $display("FAIL correct_word%0d: data=%h err=%b pos=%0d, want data=%h err=%b pos=%0d",
                             got, a_data, a_err, a_pos, want[got].data, want[got].err, want[got].pos);
                end
                got++;
            end
            if (ix) k++;
        end
        n_cmp++;
        if (got != 2 || a_cnt !== 8'd2) begin
            n_bad++;
            $display("FAIL correct_count: delivered=%0d cnt=%0d, want 2 and 2", got, a_cnt);
        end
    endtask

    task automatic test_exhaustive;
        logic ix, ox;
        logic [6:0] c;
        exp_t e, w;
        int k = 0;
        int got = 0;
        expq.delete();
        for (int t = 0; t < 140; t++) begin
            c = '0;
            if (k < 128) begin
                c = encode(4'(k / 8));
                if (k % 8 < 7) c[k % 8] = ~c[k % 8];
            end
            step_a(k < 128, c, 1'b1, 1'b0, ix, ox);
            if (ox) begin
                n_cmp++;
                if (expq.size() == 0) begin
                    n_bad++;
                    $display("FAIL exhaustive_extra: data=%h, want no output", a_data);
                end else begin
                    w = expq.pop_front();
                    if ({a_data, a_err, a_pos} !== w) begin
                        n_bad++;
                        $display("FAIL exhaustive_word%0d: data=%h err=%b pos=%0d, want data=%h err=%b pos=%0d",
                                 got, a_data, a_err, a_pos, w.data, w.err, w.pos);
                    end
                end
                got++;
            end
            if (ix) begin
                e.data = 4'(k / 8);
                e.err  = (k % 8 < 7);
                e.pos  = (k % 8 < 7) ? 3'(k % 8 + 1) : 3'd0;
                expq.push_back(e);
                k++;
            end
        end
        n_cmp++;
        if (got != 128 || expq.size() != 0 || a_cnt !== 8'd114) begin
            n_bad++;
            $display("FAIL exhaustive_totals: delivered=%0d pending=%0d cnt=%0d, want 128 0 114",
                     got, expq.size(), a_cnt);
        end
    endtask

    task automatic test_backpressure;
        logic ix, ox, ordy;
        logic stall_prev = 1'b0;
        logic [7:0] held = '0;
        logic [6:0] c;
        exp_t w;
        int ep;
        int k = 0;
        int got = 0;
        expq.delete();
        for (int t = 0; t < 20; t++) begin
            ordy = !(t >= 3 && t < 7);
            c  = encode(4'($urandom_range(0, 15)));
            ep = $urandom_range(0, 7);
            if (ep < 7) c[ep] = ~c[ep];
            step_a(k < 5, c, ordy, 1'b0, ix, ox);
            n_cmp++;
            if (a_in_ready !== ((expq.size() < 2) || ordy)) begin
                n_bad++;
                $display("FAIL bp_in_ready: cycle=%0d in_ready=%b, want %b", t, a_in_ready,
                         (expq.size() < 2) || ordy);
            end
            if (stall_prev) begin
                n_cmp++;
                if (!a_out_valid || {a_data, a_err, a_pos} !== held) begin
                    n_bad++;
                    $display("FAIL bp_hold: cycle=%0d valid=%b word=%h, want 1 and %h",
                             t, a_out_valid, {a_data, a_err, a_pos}, held);
                end
            end
            stall_prev = a_out_valid && !ordy;
            held       = {a_data, a_err, a_pos};
            if (ox) begin
                n_cmp++;
                if (expq.size() == 0) begin
                    n_bad++;
                    $display("FAIL bp_extra: data=%h, want no output", a_data);
                end else begin
                    w = expq.pop_front();
                    if ({a_data, a_err, a_pos} !== w) begin
                        n_bad++;
                        $display("FAIL bp_word%0d: data=%h err=%b pos=%0d, want data=%h err=%b pos=%0d",
                                 got, a_data, a_err, a_pos, w.data, w.err, w.pos);
                    end
                end
                got++;
            end
            if (ix) begin
                expq.push_back(model(a_code, 1'b1));
                k++;
            end
        end
        n_cmp++;
        if (got != 5 || expq.size() != 0) begin
            n_bad++;
            $display("FAIL bp_totals: delivered=%0d pending=%0d, want 5 and 0", got, expq.size());
        end
    endtask

    task automatic test_random_stream;
        logic ix, ox, v, ordy;
        logic stall_prev = 1'b0;
        logic [7:0] held = '0;
        logic [6:0] c;
        exp_t w;
        int ep;
        int k = 0;
        int got = 0;
        expq.delete();
        for (int t = 0; t < 400; t++) begin
            v    = (k < 60) && ($urandom_range(0, 9) < 7);
            ordy = (t >= 360) || ($urandom_range(0, 9) < 6);
            c  = encode(4'($urandom_range(0, 15)));
            ep = $urandom_range(0, 7);
            if (ep < 7) c[ep] = ~c[ep];
            step_a(v, c, ordy, 1'b0, ix, ox);
            n_cmp++;
            if (a_in_ready !== ((expq.size() < 2) || ordy)) begin
                n_bad++;
                $display("FAIL rnd_in_ready: cycle=%0d in_ready=%b, want %b", t, a_in_ready,
                         (expq.size() < 2) || ordy);
            end
            if (stall_prev) begin
                n_cmp++;
                if (!a_out_valid || {a_data, a_err, a_pos} !== held) begin
                    n_bad++;
                    $display("FAIL rnd_hold: cycle=%0d valid=%b word=%h, want 1 and %h",
                             t, a_out_valid, {a_data, a_err, a_pos}, held);
                end
            end
            stall_prev = a_out_valid && !ordy;
            held       = {a_data, a_err, a_pos};
            if (ox) begin
                n_cmp++;
                if (expq.size() == 0) begin
                    n_bad++;
                    $display("FAIL rnd_extra: data=%h, want no output", a_data);
                end else begin
                    w = expq.pop_front();
                    if ({a_data, a_err, a_pos} !== w) begin
                        n_bad++;
                        $display("FAIL rnd_word%0d: data=%h err=%b pos=%0d, want data=%h err=%b pos=%0d",
                                 got, a_data, a_err, a_pos, w.data, w.err, w.pos);
                    end
                end
                got++;
            end
            if (ix) begin
                expq.push_back(model(a_code, 1'b1));
                k++;
            end
        end
        n_cmp++;
        if (got != 60 || expq.size() != 0) begin
            n_bad++;
            $display("FAIL rnd_totals: delivered=%0d pending=%0d, want 60 and 0", got, expq.size());
        end
    endtask

    task automatic test_counter;
        logic ix, ox;
        step_b(1'b1, 7'h45, 1'b1, 1'b0, ix, ox);
        step_b(1'b0, 7'h00, 1'b1, 1'b0, ix, ox);
        step_b(1'b0, 7'h00, 1'b1, 1'b0, ix, ox);
        n_cmp++;
        if (!ox || b_data !== 4'h9 || b_err !== 1'b1 || b_pos !== 3'd5) begin
            n_bad++;
            $display("FAIL nocorrect: xfer=%b data=%h err=%b pos=%0d, want 1 9 1 5",
                     ox, b_data, b_err, b_pos);
        end
        for (int t = 0; t < 8; t++) begin
            step_b(t < 4, 7'h7E, 1'b1, 1'b0, ix, ox);
            if (t == 0) begin
                n_cmp++;
                if (b_cnt !== 2'd1) begin
                    n_bad++;
                    $display("FAIL cnt_first: cnt=%0d, want 1", b_cnt);
                end
            end
        end
        n_cmp++;
        if (b_cnt !== 2'd3) begin
            n_bad++;
            $display("FAIL cnt_saturate: cnt=%0d, want 3", b_cnt);
        end
        step_b(1'b1, 7'h45, 1'b1, 1'b0, ix, ox);
        step_b(1'b0, 7'h00, 1'b1, 1'b0, ix, ox);
        step_b(1'b0, 7'h00, 1'b1, 1'b1, ix, ox);
        n_cmp++;
        if (!ox || b_err !== 1'b1 || b_cnt !== 2'd3) begin
            n_bad++;
            $display("FAIL cnt_clear_setup: xfer=%b err=%b cnt=%0d, want 1 1 3", ox, b_err, b_cnt);
        end
        step_b(1'b0, 7'h00, 1'b1, 1'b0, ix, ox);
        n_cmp++;
        if (b_cnt !== 2'd0) begin
            n_bad++;
            $display("FAIL cnt_clear_priority: cnt=%0d, want 0", b_cnt);
        end
    endtask

    task automatic test_reset_midflight;
        logic ix, ox;
        logic seen = 1'b0;
        expq.delete();
        step_a(1'b1, 7'h55, 1'b0, 1'b0, ix, ox);
        step_a(1'b1, 7'h7F, 1'b0, 1'b0, ix, ox);
        step_a(1'b0, 7'h00, 1'b0, 1'b0, ix, ox);
        n_cmp++;
        if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_full: valid=%b in_ready=%b, want 1 0", a_out_valid, a_in_ready);
        end
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if (a_out_valid !== 1'b0 || a_data !== 4'h0) begin
            n_bad++;
            $display("FAIL midrst_async: valid=%b data=%h, want 0 0", a_out_valid, a_data);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int t = 0; t < 6; t++) begin
            step_a(1'b0, 7'h00, 1'b1, 1'b0, ix, ox);
            if (a_out_valid) seen = 1'b1;
        end
        n_cmp++;
        if (seen) begin
            n_bad++;
            $display("FAIL midrst_ghost: out_valid seen=1, want 0");
        end
        step_a(1'b1, 7'h00, 1'b1, 1'b0, ix, ox);
        step_a(1'b0, 7'h00, 1'b1, 1'b0, ix, ox);
        step_a(1'b0, 7'h00, 1'b1, 1'b0, ix, ox);
        n_cmp++;
        if (!ox || a_data !== 4'h0 || a_err !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_resume: xfer=%b data=%h err=%b, want 1 0 0", ox, a_data, a_err);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_clean();
        test_correct();
        test_exhaustive();
        test_backpressure();
        test_random_stream();
        test_counter();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
